// File: rtl/msi_cache_ctrl_if.sv
// CPU, shared-bus, snoop and memory signals of one MSI cache controller.
// master = controller side, slave = CPU/bus/memory environment side.
interface msi_cache_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 7,
  parameter int SRC_W  = 2,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              bus_req;
  logic              bus_gnt;
  logic [1:0]        bus_cmd;
  logic [ADDR_W-1:0] bus_addr;
  logic              snoop_valid;
  logic [1:0]        snoop_cmd;
  logic [ADDR_W-1:0] snoop_addr;
  logic [SRC_W-1:0]  snoop_src;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic [DATA_W-1:0] flush_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_gnt,
           snoop_valid, snoop_cmd, snoop_addr, snoop_src, mem_rdata, mem_ack,
    output cpu_ready, cpu_rdata, bus_req, bus_cmd, bus_addr,
           flush, flush_addr, flush_data, mem_req, mem_we, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_gnt,
           snoop_valid, snoop_cmd, snoop_addr, snoop_src, mem_rdata, mem_ack,
    input  cpu_ready, cpu_rdata, bus_req, bus_cmd, bus_addr,
           flush, flush_addr, flush_data, mem_req, mem_we, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/msi_cache_ctrl.sv
// Direct-mapped MSI snooping cache controller for one node: CPU port, bus
// broadcast, snoop handling with flush, victim writeback and upgrade-race recovery.
module msi_cache_ctrl #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 7,
  parameter int NODES  = 4,
  parameter int ID     = 0,
  parameter int CNT_W  = 16
) (
  input  logic clock,
  input  logic reset,
  msi_cache_ctrl_if.master sys
);
  localparam int IDX_W = $clog2(LINES);
  localparam int SRC_W = (NODES > 1) ? $clog2(NODES) : 1;

  localparam logic [1:0] LI = 2'd0, LS = 2'd1, LM = 2'd2;
  localparam logic [1:0] CMD_NONE = 2'b00, CMD_RD = 2'b01, CMD_WR = 2'b10, CMD_INV = 2'b11;
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, WB = 3'd2, ARB = 3'd3,
                         BUS = 3'd4, FILL = 3'd5, DONE = 3'd6;

  logic [2:0]                   state, stN;
  logic                         reqWe;
  logic [ADDR_W-1:0]            reqAddr, wbAddr;
  logic [DATA_W-1:0]            reqWdata, wbData;
  logic [1:0]                   pendCmd, pendN;
  logic [LINES-1:0][1:0]        lineSt, stArrN;
  logic [LINES-1:0][ADDR_W-1:0] lineTag, tagN;
  logic [LINES-1:0][DATA_W-1:0] lineData, dataN;
  logic [CNT_W-1:0]             hitCnt, missCnt;
  logic                         hitInc, missInc, wbLoad;
  logic                         flushN, flushR, snHit, hit;
  logic [ADDR_W-1:0]            flushAddrR;
  logic [DATA_W-1:0]            flushDataR;
  logic [IDX_W-1:0]             rIdx, sIdx;

  assign rIdx = reqAddr[IDX_W-1:0];
  assign sIdx = sys.snoop_addr[IDX_W-1:0];
  assign hit  = (lineSt[rIdx] != LI) && (lineTag[rIdx] == reqAddr);

  always_comb begin
    stN     = state;
    pendN   = pendCmd;
    stArrN  = lineSt;
    tagN    = lineTag;
    dataN   = lineData;
    hitInc  = 1'b0;
    missInc = 1'b0;
    wbLoad  = 1'b0;
    flushN  = 1'b0;
    unique case (state)
      IDLE:   if (sys.cpu_req) stN = LOOKUP;
      LOOKUP: begin
        if (hit && (!reqWe || lineSt[rIdx] == LM)) begin
          hitInc = 1'b1;
          stN    = DONE;
          if (reqWe) dataN[rIdx] = reqWdata;
        end else begin
          missInc = 1'b1;
          if (hit) begin
            pendN = CMD_INV;
            stN   = ARB;
          end else begin
            pendN = reqWe ? CMD_WR : CMD_RD;
            // Victim leaves the array now so later snoops cannot hit it.
            if (lineSt[rIdx] == LM) begin
              wbLoad       = 1'b1;
              stArrN[rIdx] = LI;
              stN          = WB;
            end else begin
              stN = ARB;
            end
          end
        end
      end
      WB:     if (sys.mem_ack) stN = ARB;
      ARB:    if (sys.bus_gnt) stN = BUS;
      BUS: begin
        if (pendCmd == CMD_INV) begin
          stArrN[rIdx] = LM;
          dataN[rIdx]  = reqWdata;
          stN          = DONE;
        end else begin
          stN = FILL;
        end
      end
      FILL: begin
        if (sys.mem_ack) begin
          tagN[rIdx]   = reqAddr;
          stArrN[rIdx] = reqWe ? LM : LS;
          dataN[rIdx]  = reqWe ? reqWdata : sys.mem_rdata;
          stN          = DONE;
        end
      end
      DONE:    stN = IDLE;
      default: stN = IDLE;
    endcase

    // Snoop acts on the line after this cycle's CPU-side update.
    snHit = sys.snoop_valid && (sys.snoop_src != SRC_W'(ID)) &&
            (stArrN[sIdx] != LI) && (tagN[sIdx] == sys.snoop_addr);
    if (snHit) begin
      unique case (sys.snoop_cmd)
        CMD_RD: if (stArrN[sIdx] == LM) begin
          flushN       = 1'b1;
          stArrN[sIdx] = LS;
        end
        CMD_WR: begin
          flushN       = (stArrN[sIdx] == LM);
          stArrN[sIdx] = LI;
        end
        CMD_INV:  stArrN[sIdx] = LI;
        default: ;
      endcase
    end

    // Lost the S copy while waiting to upgrade: finish as a write miss.
    if (state == ARB && pendCmd == CMD_INV && stArrN[rIdx] == LI) pendN = CMD_WR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      reqWe      <= 1'b0;
      reqAddr    <= '0;
      reqWdata   <= '0;
      pendCmd    <= CMD_NONE;
      wbAddr     <= '0;
      wbData     <= '0;
      lineSt     <= '0;
      lineTag    <= '0;
      lineData   <= '0;
      hitCnt     <= '0;
      missCnt    <= '0;
      flushR     <= 1'b0;
      flushAddrR <= '0;
      flushDataR <= '0;
    end else begin
      state    <= stN;
      pendCmd  <= pendN;
      lineSt   <= stArrN;
      lineTag  <= tagN;
      lineData <= dataN;
      if (state == IDLE && sys.cpu_req) begin
        reqWe    <= sys.cpu_we;
        reqAddr  <= sys.cpu_addr;
        reqWdata <= sys.cpu_wdata;
      end
      if (wbLoad) begin
        wbAddr <= lineTag[rIdx];
        wbData <= lineData[rIdx];
      end
      if (hitInc && hitCnt != '1)   hitCnt  <= hitCnt + CNT_W'(1);
      if (missInc && missCnt != '1) missCnt <= missCnt + CNT_W'(1);
      flushR     <= flushN;
      flushAddrR <= flushN ? sys.snoop_addr : '0;
      flushDataR <= flushN ? dataN[sIdx] : '0;
    end
  end

  assign sys.cpu_ready  = (state == DONE);
  assign sys.cpu_rdata  = (state == DONE) ? lineData[rIdx] : '0;
  assign sys.bus_req    = (state == ARB) || (state == BUS);
  assign sys.bus_cmd    = (state == BUS) ? pendCmd : CMD_NONE;
  assign sys.bus_addr   = (state == BUS) ? reqAddr : '0;
  assign sys.mem_req    = (state == WB) || (state == FILL);
  assign sys.mem_we     = (state == WB);
  assign sys.mem_addr   = (state == WB) ? wbAddr : ((state == FILL) ? reqAddr : '0);
  assign sys.mem_wdata  = (state == WB) ? wbData : '0;
  assign sys.flush      = flushR;
  assign sys.flush_addr = flushAddrR;
  assign sys.flush_data = flushDataR;
  assign sys.hit_cnt    = hitCnt;
  assign sys.miss_cnt   = missCnt;
endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Directed bench for msi_cache_ctrl: a transaction-level MSI model predicts bus,
// memory, flush and CPU results; a second instance covers 8 lines and 2-bit counters.
module tb_msi_cache_ctrl;
  localparam int LINES = 4, AW = 5, DW = 7, NODES = 4, SW = 2, CW = 16;
  localparam int LINES2 = 8, AW2 = 6, CW2 = 2;
  localparam int MI = 0, MS = 1, MM = 2;

  logic clock = 1'b0, reset = 1'b1, gntEn = 1'b1, monOn = 1'b0, prevMem = 1'b0;
  int nVec = 0, nErr = 0;
  always #5 clock = ~clock;

  msi_cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .SRC_W(SW), .CNT_W(CW)) cif ();
  msi_cache_ctrl_if #(.ADDR_W(AW2), .DATA_W(DW), .SRC_W(SW), .CNT_W(CW2)) cif2 ();

  msi_cache_ctrl #(.LINES(LINES), .ADDR_W(AW), .DATA_W(DW), .NODES(NODES), .ID(0), .CNT_W(CW))
    dut (.clock(clock), .reset(reset), .sys(cif.master));
  msi_cache_ctrl #(.LINES(LINES2), .ADDR_W(AW2), .DATA_W(DW), .NODES(NODES), .ID(0), .CNT_W(CW2))
    dut2 (.clock(clock), .reset(reset), .sys(cif2.master));

  assign cif.bus_gnt  = cif.bus_req & gntEn;
  assign cif2.bus_gnt = cif2.bus_req;

  // Model: line contents, memory image, counters and queues of expected events.
  typedef struct { logic [1:0] cmd; logic [AW-1:0] addr; } busEv_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } memEv_t;
  busEv_t busQ[$];
  memEv_t memQ[$];
  int mSt[LINES];
  logic [AW-1:0] mTag[LINES];
  logic [DW-1:0] mData[LINES];
  logic [DW-1:0] mMem[32], rMem[32], rMem2[64];
  int mHit = 0, mMiss = 0;
  logic [DW-1:0] expRd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Compare process: every negedge, check any bus/memory/CPU activity against the model.
  always @(negedge clock) begin
    if (monOn && !reset) begin
      if (cif.bus_cmd != 2'b00) begin
        if (busQ.size() == 0) check("unexpected bus_cmd", 32'(cif.bus_cmd), 0);
        else begin
          check("bus_cmd", 32'(cif.bus_cmd), 32'(busQ[0].cmd));
          check("bus_addr", 32'(cif.bus_addr), 32'(busQ[0].addr));
          check("bus_req with cmd", 32'(cif.bus_req), 1);
          busQ.delete(0);
        end
      end
      if (cif.mem_req && !prevMem) begin
        if (memQ.size() == 0) check("unexpected mem_req", 32'(cif.mem_req), 0);
        else begin
          check("mem_we", 32'(cif.mem_we), 32'(memQ[0].we));
          check("mem_addr", 32'(cif.mem_addr), 32'(memQ[0].addr));
          check("mem_wdata", 32'(cif.mem_wdata), 32'(memQ[0].data));
          memQ.delete(0);
        end
      end
      if (cif.cpu_ready) begin
        check("cpu_rdata", 32'(cif.cpu_rdata), 32'(expRd));
        check("hit_cnt", 32'(cif.hit_cnt), 32'(mHit));
        check("miss_cnt", 32'(cif.miss_cnt), 32'(mMiss));
      end
      prevMem <= cif.mem_req;
    end
  end

  // Memory for both instances: acknowledge one cycle after a request appears.
  initial begin
    cif.mem_ack = 1'b0; cif.mem_rdata = '0; cif2.mem_ack = 1'b0; cif2.mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (cif.mem_ack) cif.mem_ack = 1'b0;
      else if (cif.mem_req && !reset) begin
        if (cif.mem_we) rMem[cif.mem_addr] = cif.mem_wdata;
        else cif.mem_rdata = rMem[cif.mem_addr];
        cif.mem_ack = 1'b1;
      end
      if (cif2.mem_ack) cif2.mem_ack = 1'b0;
      else if (cif2.mem_req && !reset) begin
        if (cif2.mem_we) rMem2[cif2.mem_addr] = cif2.mem_wdata;
        else cif2.mem_rdata = rMem2[cif2.mem_addr];
        cif2.mem_ack = 1'b1;
      end
    end
  end

  task automatic driveSnoop(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [SW-1:0] src,
                            input logic expF, input logic [AW-1:0] expA, input logic [DW-1:0] expD);
    @(posedge clock); #1;
    cif.snoop_valid = 1'b1; cif.snoop_cmd = cmd; cif.snoop_addr = addr; cif.snoop_src = src;
    @(posedge clock); #1;
    cif.snoop_valid = 1'b0;
    @(negedge clock);
    check("flush", 32'(cif.flush), 32'(expF));
    check("flush_addr", 32'(cif.flush_addr), expF ? 32'(expA) : 0);
    check("flush_data", 32'(cif.flush_data), expF ? 32'(expD) : 0);
  endtask

  task automatic doSnoop(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [SW-1:0] src);
    int i;
    logic f;
    logic [DW-1:0] d;
    i = int'(addr) % LINES;
    f = 1'b0;
    d = mData[i];
    if (src != 0 && mSt[i] != MI && mTag[i] == addr) begin
      if (cmd == 2'b01 && mSt[i] == MM) begin f = 1'b1; mSt[i] = MS; end
      else if (cmd == 2'b10) begin f = (mSt[i] == MM); mSt[i] = MI; end
      else if (cmd == 2'b11) mSt[i] = MI;
    end
    driveSnoop(cmd, addr, src, f, addr, d);
  endtask

  task automatic doOp(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input bit race, output logic [DW-1:0] rd, output int lat);
    int i;
    bit h;
    i = int'(addr) % LINES;
    h = (mSt[i] != MI) && (mTag[i] == addr);
    if (h && (!we || mSt[i] == MM)) begin
      if (mHit < 65535) mHit++;
      if (we) mData[i] = wd;
    end else begin
      if (mMiss < 65535) mMiss++;
      if (h && !race) busQ.push_back('{cmd: 2'b11, addr: addr});
      else begin
        if (!h && mSt[i] == MM) begin
          memQ.push_back('{we: 1'b1, addr: mTag[i], data: mData[i]});
          mMem[mTag[i]] = mData[i];
        end
        busQ.push_back('{cmd: we ? 2'b10 : 2'b01, addr: addr});
        memQ.push_back('{we: 1'b0, addr: addr, data: '0});
        mTag[i] = addr;
        mData[i] = mMem[addr];
      end
      mSt[i] = we ? MM : MS;
      if (we) mData[i] = wd;
    end
    expRd = mData[i];
    if (race) gntEn = 1'b0;
    @(posedge clock); #1;
    cif.cpu_req = 1'b1; cif.cpu_we = we; cif.cpu_addr = addr; cif.cpu_wdata = wd;
    if (race) begin
      for (int k = 0; k < 20 && !cif.bus_req; k++) @(negedge clock);
      driveSnoop(2'b11, addr, 2'd2, 1'b0, '0, '0);
      gntEn = 1'b1;
    end
    lat = 0;
    while (lat < 100) begin
      @(negedge clock);
      lat++;
      if (cif.cpu_ready) break;
    end
    check("cpu_ready seen", 32'(cif.cpu_ready), 1);
    rd = cif.cpu_rdata;
    @(posedge clock); #1;
    cif.cpu_req = 1'b0;
    check("bus events pending", busQ.size(), 0);
    check("mem events pending", memQ.size(), 0);
  endtask

  task automatic op2(input logic we, input logic [AW2-1:0] addr, input logic [DW-1:0] wd,
                     output logic [DW-1:0] rd);
    int n;
    @(posedge clock); #1;
    cif2.cpu_req = 1'b1; cif2.cpu_we = we; cif2.cpu_addr = addr; cif2.cpu_wdata = wd;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      n++;
      if (cif2.cpu_ready) break;
    end
    check("dut2 cpu_ready seen", 32'(cif2.cpu_ready), 1);
    rd = cif2.cpu_rdata;
    @(posedge clock); #1;
    cif2.cpu_req = 1'b0;
  endtask

  task automatic modelReset();
    for (int k = 0; k < LINES; k++) begin mSt[k] = MI; mTag[k] = '0; mData[k] = '0; end
    mHit = 0; mMiss = 0;
    busQ.delete(); memQ.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    int lat;
    cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; cif.cpu_addr = '0; cif.cpu_wdata = '0;
    cif.snoop_valid = 1'b0; cif.snoop_cmd = '0; cif.snoop_addr = '0; cif.snoop_src = '0;
    cif2.cpu_req = 1'b0; cif2.cpu_we = 1'b0; cif2.cpu_addr = '0; cif2.cpu_wdata = '0;
    cif2.snoop_valid = 1'b0; cif2.snoop_cmd = '0; cif2.snoop_addr = '0; cif2.snoop_src = '0;
    for (int a = 0; a < 32; a++) begin mMem[a] = DW'(a); rMem[a] = DW'(a); end
    for (int a = 0; a < 64; a++) rMem2[a] = DW'(a);
    modelReset();

    #12;
    check("reset cpu_ready", 32'(cif.cpu_ready), 0);
    check("reset bus_req", 32'(cif.bus_req), 0);
    check("reset bus_cmd", 32'(cif.bus_cmd), 0);
    check("reset mem_req", 32'(cif.mem_req), 0);
    check("reset flush", 32'(cif.flush), 0);
    check("reset hit_cnt", 32'(cif.hit_cnt), 0);
    check("reset miss_cnt", 32'(cif.miss_cnt), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    monOn = 1'b1;

    // Read miss, upgrade, victim writeback, then a hit with its latency.
    doOp(1'b0, 5'd8, '0, 0, rd, lat);
    check("t1 read 8 data", 32'(rd), 8);
    check("t1 miss_cnt", 32'(cif.miss_cnt), 1);
    doOp(1'b1, 5'd8, 7'd30, 0, rd, lat);
    check("t2 upgrade data", 32'(rd), 30);
    doOp(1'b0, 5'd12, '0, 0, rd, lat);
    check("t3 read 12 data", 32'(rd), 12);
    check("t3 victim in memory", 32'(rMem[8]), 30);
    doOp(1'b0, 5'd12, '0, 0, rd, lat);
    check("t3 hit latency", 32'(lat), 3);
    check("t3 hit_cnt", 32'(cif.hit_cnt), 1);

    // Snoop transitions on line 2.
    doOp(1'b1, 5'd10, 7'd30, 0, rd, lat);
    doSnoop(2'b01, 5'd10, 2'd0);
    doSnoop(2'b01, 5'd10, 2'd1);
    doOp(1'b0, 5'd10, '0, 0, rd, lat);
    check("t4 S after flush hits", 32'(rd), 30);
    doSnoop(2'b10, 5'd10, 2'd3);
    doOp(1'b0, 5'd10, '0, 0, rd, lat);
    doOp(1'b1, 5'd10, 7'd77, 0, rd, lat);
    doSnoop(2'b10, 5'd10, 2'd1);
    doOp(1'b1, 5'd14, 7'd5, 0, rd, lat);
    doSnoop(2'b11, 5'd14, 2'd1);
    doOp(1'b0, 5'd14, '0, 0, rd, lat);
    check("t4 reread 14", 32'(rd), 14);

    // Upgrade race: S copy invalidated while waiting for the bus.
    doOp(1'b0, 5'd6, '0, 0, rd, lat);
    doOp(1'b1, 5'd6, 7'd50, 1, rd, lat);
    check("t5 race write data", 32'(rd), 50);
    doSnoop(2'b01, 5'd6, 2'd1);
    doSnoop(2'b01, 5'd22, 2'd1);

    // Reset during a fill drops everything.
    monOn = 1'b0;
    @(posedge clock); #1;
    cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 5'd20;
    for (int k = 0; k < 20 && !cif.mem_req; k++) @(negedge clock);
    check("t7 fill in flight", 32'(cif.mem_req), 1);
    reset = 1'b1;
    #1;
    check("t7 mem_req dropped", 32'(cif.mem_req), 0);
    check("t7 miss_cnt cleared", 32'(cif.miss_cnt), 0);
    cif.cpu_req = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    modelReset();
    monOn = 1'b1;
    doOp(1'b0, 5'd8, '0, 0, rd, lat);
    check("t7 read 8 after reset", 32'(rd), 30);
    check("t7 miss_cnt", 32'(cif.miss_cnt), 1);

    // Eight lines, 2-bit counters: 13, 5 and 45 share index 5.
    op2(1'b0, 6'd13, '0, rd);
    check("t6 read 13", 32'(rd), 13);
    op2(1'b1, 6'd13, 7'h55, rd);
    op2(1'b0, 6'd5, '0, rd);
    check("t6 read 5", 32'(rd), 5);
    check("t6 13 evicted by 5", 32'(rMem2[13]), 32'h55);
    op2(1'b0, 6'd45, '0, rd);
    check("t6 miss_cnt saturated", 32'(cif2.miss_cnt), 3);
    for (int k = 1; k <= 5; k++) begin
      op2(1'b0, 6'd45, '0, rd);
      check("t6 hit data", 32'(rd), 45);
      check("t6 hit_cnt", 32'(cif2.hit_cnt), (k < 3) ? k : 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/msi_cache_ctrl.md
Name: msi_cache_ctrl

Overview:
Parametrised per-processor MSI snooping cache controller, the successor to the fixed 4-line, 3-processor snooping model. Each instance is a direct-mapped cache of LINES lines holding the coherency state (I/S/M), tag and data for each line. It serves one CPU port, broadcasts coherency messages on the shared bus, and snoops other nodes' messages. Self-snoop filtering, victim writeback, snoop-driven flush and upgrade-race recovery are built in; the top level instantiates NODES copies around one arbiter and one memory.

Parameters:
LINES, 4, cache lines (power of 2, ≥2); IDX_W = log2(LINES), derived
ADDR_W, 5, address width; the full address is stored as the tag; index = addr[IDX_W-1:0]
DATA_W, 7, data word width
NODES, 4, node count on the bus; SRC_W = max(1, log2(NODES)), derived
ID, 0, this node's identifier, 0..NODES-1
CNT_W, 16, width of the hit and miss counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU request valid; held until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid with cpu_ready
bus_req  out  1  bus request to the arbiter
bus_gnt  in  1  bus grant
bus_cmd  out  2  00 none, 01 read miss, 10 write miss, 11 invalidate
bus_addr  out  ADDR_W  address broadcast with bus_cmd
snoop_valid  in  1  a bus message is present
snoop_cmd  in  2  same encoding as bus_cmd
snoop_addr  in  ADDR_W  snooped address
snoop_src  in  SRC_W  ID of the originating node
flush  out  1  one-cycle pulse: M copy written back because of a snoop
flush_addr  out  ADDR_W  address of the flushed line
flush_data  out  DATA_W  data of the flushed line
mem_req  out  1  memory access request; held until mem_ack
mem_we  out  1  1 = writeback, 0 = fill
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  writeback data
mem_rdata  in  DATA_W  fill data, valid with mem_ack
mem_ack  in  1  memory completion pulse
hit_cnt  out  CNT_W  saturating count of hits
miss_cnt  out  CNT_W  saturating count of misses, including upgrades

Behaviour:
- Reset: every line is I with tag 0 and data 0; FSM goes to IDLE. All outputs are 0, including both counters.
- FSM states: IDLE, LOOKUP, WB, ARB, BUS, FILL, DONE.
- IDLE: when cpu_req=1, latch we/addr/wdata and go to LOOKUP.
- LOOKUP (hit = line state ≠ I and tag == addr):
  - read hit on S or M → DONE; hit_cnt +1.
  - write hit on M → write the data → DONE; hit_cnt +1.
  - write hit on S → ARB with pending cmd = 11; miss_cnt +1.
  - miss with victim in M → WB; miss_cnt +1.
  - miss otherwise → ARB; miss_cnt +1.
  - pending cmd for a miss is 01 for a read and 10 for a write.
- WB:
  - On WB entry, latch the victim's tag and data into a writeback buffer and set the victim line to I. From then on, snoops miss the victim.
  - Assert mem_req=1, mem_we=1 with the victim's address and data; on mem_ack → ARB.
- ARB: assert bus_req=1; on bus_gnt → BUS.
- BUS: exactly one cycle with bus_cmd/bus_addr driven and bus_req still 1.
  - After cmd 11: set the line to M, write the data → DONE.
  - After cmd 01/10 → FILL.
- Upgrade race:
  - Applies in ARB with pending cmd 11, when a snoop invalidates the target line (state goes to I).
  - Pending cmd becomes 10 and the request completes as a write miss through FILL.
- FILL:
  - Assert mem_req=1, mem_we=0 at the latched address.
  - On mem_ack, install the tag and mem_rdata. A read leaves the line in S. A write leaves it in M with the data replaced by cpu_wdata.
  - Then → DONE.
- DONE: cpu_ready=1 for one cycle. cpu_rdata is the line data after the operation (for a write, the written value). Then → IDLE.
- Latency: a hit gives cpu_ready 2 cycles after IDLE samples cpu_req.
- Snoop:
  - Evaluated every cycle, in every state, whenever snoop_valid=1, snoop_src≠ID and the indexed line has state≠I and a matching tag.
  - read miss on M → flush, state S.
  - write miss on M → flush, state I.
  - write miss or invalidate on S → I.
  - read miss on S → unchanged.
  - invalidate on M → I, no flush (this is a protocol error upstream).
- Flush timing: flush/flush_addr/flush_data are registered, valid the cycle after the snoop. The top level orders flush writes ahead of any fill mem_req issued in the same cycle.
- Snoop vs. same-cycle CPU update of the same line: the CPU write lands first, then the snoop transition applies to the result.
- Counters saturate at all-ones.
- Reset asserted mid-operation aborts at once. Any in-flight writeback or fill is discarded and the memory side retries nothing.

Test Plan:
1. LINES=4, ID=0: reset → all lines I, counters 0. Read 8 → bus_cmd=01 addr 8, mem_rdata=8 → line 0 S, cpu_rdata=8, miss_cnt=1.
2. Line 0 S/8; write 8 value 30 → ARB, bus_cmd=11 for one cycle → line 0 M data 30, no mem_req.
3. Line 0 M tag 8 data 30; read 12 → mem_we=1 addr 8 data 30, then bus_cmd=01 addr 12, fill → line 0 S/12.
4. Line 2 M tag 10 data 30; snoop read miss 10 from src 1 → next cycle flush=1 addr 10 data 30, line S. Same stimulus with snoop_src=0 → no change.
5. Upgrade race: write hit on S, hold bus_gnt=0, inject an invalidate of that line from src 2 → bus_cmd=10 issued, FILL performed, line ends M with the CPU data.
6. LINES=8, ADDR_W=6, CNT_W=2: five read hits → hit_cnt saturates at 3. Address 13 maps to index 5.
